// File: rtl/dmem_responder.sv
// Target end of the core's data-memory port. Requests are accepted one at a time and
// answered after a fixed extra latency, with byte/half/word access and alignment errors.
module dmem_responder #(
  parameter int ADDR_W  = 15,
  parameter int LATENCY = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [31:0]       rsp_rdata,
  output logic              rsp_err
);
  localparam int         DEPTH = 2 ** (ADDR_W - 2);
  localparam logic [3:0] LAT4  = 4'(LATENCY);

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_WAIT = 2'd1, S_RESP = 2'd2} state_t;

  state_t            r_state, w_state_nxt;
  logic [3:0]        r_cnt, w_cnt_nxt;
  logic              w_accept, w_enter_resp, w_sel_in;
  logic              r_we, r_uns;
  logic [1:0]        r_size;
  logic [ADDR_W-1:0] r_addr;
  logic [31:0]       r_wdata;
  logic              w_we, w_uns, w_err;
  logic [1:0]        w_size;
  logic [ADDR_W-1:0] w_addr;
  logic [ADDR_W-3:0] w_idx;
  logic [31:0]       w_wdata, w_old, w_shift, w_mask, w_wword, w_load;
  logic              r_rsp_valid, r_rsp_err;
  logic [31:0]       r_rsp_rdata;
  logic [31:0]       r_mem [DEPTH];

  assign req_ready    = !rst && (r_state == S_IDLE);
  assign w_enter_resp = !rst && (r_state != S_RESP) && (w_state_nxt == S_RESP);
  assign rsp_valid    = r_rsp_valid;
  assign rsp_rdata    = r_rsp_rdata;
  assign rsp_err      = r_rsp_err;

  // With zero latency the array is touched on the accept edge, before the holding regs load.
  assign w_sel_in = (r_state == S_IDLE);
  assign w_we     = w_sel_in ? req_we       : r_we;
  assign w_size   = w_sel_in ? req_size     : r_size;
  assign w_uns    = w_sel_in ? req_unsigned : r_uns;
  assign w_addr   = w_sel_in ? req_addr     : r_addr;
  assign w_wdata  = w_sel_in ? req_wdata    : r_wdata;
  assign w_idx    = w_addr[ADDR_W-1:2];
  assign w_old    = r_mem[w_idx];
  assign w_shift  = w_old >> {w_addr[1:0], 3'b000};

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_accept    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (req_valid) begin
          w_accept    = 1'b1;
          w_cnt_nxt   = LAT4;
          w_state_nxt = (LAT4 == 4'd0) ? S_RESP : S_WAIT;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_WAIT: begin
        w_cnt_nxt = r_cnt - 4'd1;
        if (r_cnt == 4'd1) begin
          w_state_nxt = S_RESP;
        end else begin
          w_state_nxt = S_WAIT;
        end
      end
      S_RESP: begin
        if (rsp_ready) begin
          w_state_nxt = S_IDLE;
        end else begin
          w_state_nxt = S_RESP;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    w_err   = 1'b0;
    w_mask  = 32'h0000_0000;
    w_wword = 32'h0000_0000;
    w_load  = 32'h0000_0000;
    case (w_size)
      2'b00: begin
        w_mask  = 32'h0000_00FF << {w_addr[1:0], 3'b000};
        w_wword = {24'h00_0000, w_wdata[7:0]} << {w_addr[1:0], 3'b000};
        w_load  = w_uns ? {24'h00_0000, w_shift[7:0]} : {{24{w_shift[7]}}, w_shift[7:0]};
      end
      2'b01: begin
        w_err   = w_addr[0];
        w_mask  = 32'h0000_FFFF << {w_addr[1], 4'b0000};
        w_wword = {16'h0000, w_wdata[15:0]} << {w_addr[1], 4'b0000};
        w_load  = w_uns ? {16'h0000, w_shift[15:0]} : {{16{w_shift[15]}}, w_shift[15:0]};
      end
      2'b10: begin
        w_err   = (w_addr[1:0] != 2'b00);
        w_mask  = 32'hFFFF_FFFF;
        w_wword = w_wdata;
        w_load  = w_old;
      end
      default: w_err = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_cnt   <= 4'd0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_we    <= 1'b0;
      r_size  <= 2'b00;
      r_uns   <= 1'b0;
      r_addr  <= '0;
      r_wdata <= 32'h0000_0000;
    end else if (w_accept) begin
      r_we    <= req_we;
      r_size  <= req_size;
      r_uns   <= req_unsigned;
      r_addr  <= req_addr;
      r_wdata <= req_wdata;
    end
  end

  // Store commit happens only on the edge entering RESP, so a reset in WAIT drops it.
  always_ff @(posedge clk) begin
    if (w_enter_resp && w_we && !w_err) begin
      r_mem[w_idx] <= (w_old & ~w_mask) | (w_wword & w_mask);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rsp_valid <= 1'b0;
      r_rsp_err   <= 1'b0;
      r_rsp_rdata <= 32'h0000_0000;
    end else if (w_enter_resp) begin
      r_rsp_valid <= 1'b1;
      r_rsp_err   <= w_err;
      r_rsp_rdata <= (w_we || w_err) ? 32'h0000_0000 : w_load;
    end else if ((r_state == S_RESP) && rsp_ready) begin
      r_rsp_valid <= 1'b0;
      r_rsp_err   <= 1'b0;
      r_rsp_rdata <= 32'h0000_0000;
    end
  end
endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: a LATENCY=2 instance (a_*) and a LATENCY=0 instance (b_*)
// checked against a byte-addressed reference memory.
module tb_dmem_responder;
  logic        clk, rst;
  logic        req_we, req_unsigned;
  logic [1:0]  req_size;
  logic [14:0] req_addr;
  logic [31:0] req_wdata;
  logic        a_req_valid, a_req_ready, a_rsp_valid, a_rsp_ready, a_rsp_err;
  logic        b_req_valid, b_req_ready, b_rsp_valid, b_rsp_ready, b_rsp_err;
  logic [31:0] a_rsp_rdata, b_rsp_rdata;
  int          errors = 0;
  int          checks = 0;
  logic [7:0]  mb_a [int];
  logic [7:0]  mb_b [int];

  dmem_responder #(.ADDR_W(15), .LATENCY(2)) u_dut_a (
    .clk(clk), .rst(rst), .req_valid(a_req_valid), .req_ready(a_req_ready),
    .req_we(req_we), .req_size(req_size), .req_unsigned(req_unsigned),
    .req_addr(req_addr), .req_wdata(req_wdata), .rsp_valid(a_rsp_valid),
    .rsp_ready(a_rsp_ready), .rsp_rdata(a_rsp_rdata), .rsp_err(a_rsp_err));

  dmem_responder #(.ADDR_W(15), .LATENCY(0)) u_dut_b (
    .clk(clk), .rst(rst), .req_valid(b_req_valid), .req_ready(b_req_ready),
    .req_we(req_we), .req_size(req_size), .req_unsigned(req_unsigned),
    .req_addr(req_addr), .req_wdata(req_wdata), .rsp_valid(b_rsp_valid),
    .rsp_ready(b_rsp_ready), .rsp_rdata(b_rsp_rdata), .rsp_err(b_rsp_err));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic bit mdl_err(logic [1:0] size, int addr);
    return (size == 2'b11) || (size == 2'b01 && addr % 2 != 0) || (size == 2'b10 && addr % 4 != 0);
  endfunction

  function automatic void mdl_store(bit sel, logic [1:0] size, int addr, logic [31:0] wdata);
    int n = 1 << size;
    for (int k = 0; k < n; k++) begin
      if (sel) mb_b[addr + k] = wdata[8*k +: 8];
      else     mb_a[addr + k] = wdata[8*k +: 8];
    end
  endfunction

  function automatic logic [31:0] mdl_load(bit sel, logic [1:0] size, bit uns, int addr);
    int n = 1 << size;
    logic [31:0] v = 32'h0;
    for (int k = 0; k < n; k++)
      v = v | ({24'h0, (sel ? mb_b[addr + k] : mb_a[addr + k])} << (8 * k));
    if (!uns && v[8*n-1] && n < 4) v = v | (32'hFFFF_FFFF << (8 * n));
    return v;
  endfunction

  // One complete transaction: present, wait for accept, wait for response, release it.
  task automatic xact(input bit sel, input bit we, input logic [1:0] size, input bit uns,
                      input logic [14:0] addr, input logic [31:0] wdata,
                      output logic [31:0] rdata, output logic err, output int lat);
    int n;
    @(negedge clk);
    req_we = we; req_size = size; req_unsigned = uns; req_addr = addr; req_wdata = wdata;
    if (sel) b_req_valid = 1'b1; else a_req_valid = 1'b1;
    n = 0;
    while (!(sel ? b_req_ready : a_req_ready) && n < 50) begin @(negedge clk); n++; end
    @(posedge clk);
    @(negedge clk);
    a_req_valid = 1'b0; b_req_valid = 1'b0;
    lat = 1;
    while (!(sel ? b_rsp_valid : a_rsp_valid) && lat < 50) begin @(negedge clk); lat++; end
    if (n >= 50 || lat >= 50) begin
      checks++; errors++;
      $display("FAIL timeout: sel=%0d addr=%h accept_wait=%0d rsp_wait=%0d required<50", sel, addr, n, lat);
    end
    rdata = sel ? b_rsp_rdata : a_rsp_rdata;
    err   = sel ? b_rsp_err : a_rsp_err;
    if (sel) b_rsp_ready = 1'b1; else a_rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    a_rsp_ready = 1'b0; b_rsp_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    checks++; if (a_rsp_valid !== 1'b0 || a_rsp_err !== 1'b0 || a_rsp_rdata !== 32'h0) begin
      errors++; $display("FAIL reset_rsp: got v=%b e=%b d=%h required 0/0/0", a_rsp_valid, a_rsp_err, a_rsp_rdata); end
    checks++; if (a_req_ready !== 1'b0 || b_req_ready !== 1'b0) begin
      errors++; $display("FAIL reset_ready: got a=%b b=%b required 0", a_req_ready, b_req_ready); end
    rst = 1'b0;
    #1;
    checks++; if (a_req_ready !== 1'b1 || b_req_ready !== 1'b1) begin
      errors++; $display("FAIL post_reset_ready: got a=%b b=%b required 1", a_req_ready, b_req_ready); end
  endtask

  task automatic test_store_load();
    logic [31:0] d; logic e; int lat;
    xact(0, 1'b1, 2'b10, 1'b0, 15'h0010, 32'hDEADBEEF, d, e, lat);
    mdl_store(0, 2'b10, 'h10, 32'hDEADBEEF);
    checks++; if (lat !== 3) begin errors++; $display("FAIL sw_latency: got %0d required 3", lat); end
    checks++; if (e !== 1'b0 || d !== 32'h0) begin
      errors++; $display("FAIL sw_rsp: got e=%b d=%h required 0/0", e, d); end
    xact(0, 1'b0, 2'b10, 1'b0, 15'h0010, 32'h0, d, e, lat);
    checks++; if (d !== 32'hDEADBEEF || e !== 1'b0) begin
      errors++; $display("FAIL lw: got %h e=%b required deadbeef e=0", d, e); end
  endtask

  task automatic test_subword();
    logic [31:0] d; logic e; int lat;
    logic [1:0]  sz [5]  = '{2'b00, 2'b00, 2'b00, 2'b01, 2'b01};
    bit          un [5]  = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    logic [14:0] ad [5]  = '{15'h11, 15'h11, 15'h11, 15'h12, 15'h12};
    logic [31:0] ex [5]  = '{32'h0, 32'hFFFFFFAA, 32'h000000AA, 32'h0000DEAD, 32'hFFFFDEAD};
    xact(0, 1'b1, 2'b00, 1'b0, 15'h0011, 32'h000000AA, d, e, lat);
    mdl_store(0, 2'b00, 'h11, 32'h000000AA);
    for (int i = 1; i < 5; i++) begin
      xact(0, 1'b0, sz[i], un[i], ad[i], 32'h0, d, e, lat);
      checks++; if (d !== ex[i] || e !== 1'b0) begin
        errors++; $display("FAIL subword_load%0d: got %h e=%b required %h e=0", i, d, e, ex[i]); end
    end
    xact(0, 1'b0, 2'b10, 1'b0, 15'h0010, 32'h0, d, e, lat);
    checks++; if (d !== 32'hDEADAAEF) begin errors++; $display("FAIL sb_word: got %h required deadaaef", d); end
  endtask

  task automatic test_misaligned();
    logic [31:0] d; logic e; int lat;
    bit          we [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
    logic [1:0]  sz [4] = '{2'b01, 2'b10, 2'b11, 2'b11};
    logic [14:0] ad [4] = '{15'h13, 15'h12, 15'h10, 15'h10};
    for (int i = 0; i < 4; i++) begin
      xact(0, we[i], sz[i], 1'b0, ad[i], 32'h55667788, d, e, lat);
      checks++; if (e !== 1'b1 || d !== 32'h0) begin
        errors++; $display("FAIL misaligned%0d: got e=%b d=%h required e=1 d=0", i, e, d); end
    end
    xact(0, 1'b0, 2'b10, 1'b0, 15'h0010, 32'h0, d, e, lat);
    checks++; if (d !== 32'hDEADAAEF) begin errors++; $display("FAIL err_nowrite: got %h required deadaaef", d); end
  endtask

  task automatic test_backpressure();
    int n;
    @(negedge clk);
    req_we = 1'b0; req_size = 2'b10; req_unsigned = 1'b0; req_addr = 15'h0010; a_req_valid = 1'b1;
    n = 0;
    @(posedge clk);
    @(negedge clk);
    while (!a_rsp_valid && n < 20) begin @(negedge clk); n++; end
    for (int i = 0; i < 5; i++) begin
      checks++; if (a_rsp_valid !== 1'b1 || a_rsp_rdata !== 32'hDEADAAEF || a_req_ready !== 1'b0) begin
        errors++; $display("FAIL bp_hold%0d: got v=%b d=%h rdy=%b required 1/deadaaef/0",
                           i, a_rsp_valid, a_rsp_rdata, a_req_ready); end
      @(negedge clk);
    end
    a_rsp_ready = 1'b1;
    @(posedge clk);
    #1 a_rsp_ready = 1'b0;
    @(negedge clk);
    checks++; if (a_rsp_valid !== 1'b0 || a_req_ready !== 1'b1) begin
      errors++; $display("FAIL bp_release: got v=%b rdy=%b required 0/1", a_rsp_valid, a_req_ready); end
    @(posedge clk);
    @(negedge clk);
    a_req_valid = 1'b0;
    n = 0;
    while (!a_rsp_valid && n < 20) begin @(negedge clk); n++; end
    checks++; if (a_rsp_valid !== 1'b1 || a_rsp_rdata !== 32'hDEADAAEF) begin
      errors++; $display("FAIL bp_second: got v=%b d=%h required 1/deadaaef", a_rsp_valid, a_rsp_rdata); end
    a_rsp_ready = 1'b1;
    @(posedge clk);
    #1 a_rsp_ready = 1'b0;
  endtask

  task automatic test_reset_midop();
    logic [31:0] d; logic e; int lat;
    xact(0, 1'b1, 2'b10, 1'b0, 15'h0020, 32'hCAFEF00D, d, e, lat);
    mdl_store(0, 2'b10, 'h20, 32'hCAFEF00D);
    @(negedge clk);
    req_we = 1'b1; req_size = 2'b10; req_addr = 15'h0020; req_wdata = 32'h12345678; a_req_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    a_req_valid = 1'b0; rst = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      checks++; if (a_rsp_valid !== 1'b0 || a_req_ready !== 1'b0) begin
        errors++; $display("FAIL midop_rst%0d: got v=%b rdy=%b required 0/0", i, a_rsp_valid, a_req_ready); end
    end
    rst = 1'b0;
    xact(0, 1'b0, 2'b10, 1'b0, 15'h0020, 32'h0, d, e, lat);
    checks++; if (d !== 32'hCAFEF00D) begin errors++; $display("FAIL midop_drop: got %h required cafef00d", d); end
  endtask

  task automatic test_random();
    logic [31:0] d, wd, ex; logic e; int lat; logic [1:0] sz; bit we, un; int a;
    for (int w = 0; w < 8; w++) begin
      wd = $urandom;
      xact(0, 1'b1, 2'b10, 1'b0, 15'(32'h100 + 4 * w), wd, d, e, lat);
      mdl_store(0, 2'b10, 'h100 + 4 * w, wd);
    end
    for (int i = 0; i < 40; i++) begin
      sz = 2'($urandom_range(0, 3)); we = 1'($urandom_range(0, 1)); un = 1'($urandom_range(0, 1));
      a = 'h100 + $urandom_range(0, 31); wd = $urandom;
      xact(0, we, sz, un, 15'(a), wd, d, e, lat);
      ex = 32'h0;
      if (!mdl_err(sz, a)) begin
        if (we) mdl_store(0, sz, a, wd);
        else    ex = mdl_load(0, sz, un, a);
      end
      checks++; if (e !== 1'(mdl_err(sz, a)) || d !== ex || lat !== 3) begin
        errors++; $display("FAIL random%0d: we=%0d sz=%0d a=%h got d=%h e=%b lat=%0d required d=%h e=%b lat=3",
                           i, we, sz, a, d, e, lat, ex, mdl_err(sz, a)); end
    end
  endtask

  task automatic test_lat0();
    logic [31:0] d, wd; logic e; int lat;
    wd = $urandom;
    xact(1, 1'b1, 2'b10, 1'b0, 15'h7FFC, wd, d, e, lat);
    mdl_store(1, 2'b10, 'h7FFC, wd);
    checks++; if (lat !== 1 || e !== 1'b0) begin errors++; $display("FAIL lat0_sw: got lat=%0d e=%b required 1/0", lat, e); end
    xact(1, 1'b0, 2'b10, 1'b0, 15'h7FFC, 32'h0, d, e, lat);
    checks++; if (d !== mdl_load(1, 2'b10, 1'b0, 'h7FFC) || lat !== 1) begin
      errors++; $display("FAIL lat0_lw_top: got %h lat=%0d required %h lat=1", d, lat, wd); end
    @(negedge clk);
    req_we = 1'b0; req_size = 2'b10; req_unsigned = 1'b0; req_addr = 15'h7FFC;
    b_req_valid = 1'b1; b_rsp_ready = 1'b1;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      checks++; if (b_rsp_valid !== 1'((i % 2) == 0) || (b_rsp_valid === 1'b1 && b_rsp_rdata !== wd)) begin
        errors++; $display("FAIL b2b%0d: got v=%b d=%h required v=%b d=%h", i, b_rsp_valid, b_rsp_rdata, (i % 2) == 0, wd); end
    end
    b_req_valid = 1'b0;
    @(negedge clk);
    b_rsp_ready = 1'b0;
  endtask

  initial begin
    rst = 1'b1; req_we = 1'b0; req_size = 2'b00; req_unsigned = 1'b0; req_addr = '0; req_wdata = '0;
    a_req_valid = 1'b0; a_rsp_ready = 1'b0; b_req_valid = 1'b0; b_rsp_ready = 1'b0;
    test_reset();
    test_store_load();
    test_subword();
    test_misaligned();
    test_backpressure();
    test_reset_midop();
    test_random();
    test_lat0();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
